// File: rtl/branch_issue_scheduler_pkg.sv
// Shared types and constants for the branch issue scheduler.
// Optional macro BRANCH_SCHED_BYPASS_EN (used by the top level) enables same-cycle dispatch-to-issue.
package branch_issue_scheduler_pkg;

    localparam int PKG_PREG_W = 7;
    localparam int PKG_ROB_W  = 5;

    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [2:0] F3_BNE     = 3'b001;

    typedef struct packed {
        logic [6:0]            Opcode;
        logic [2:0]            func3;
        logic [PKG_PREG_W-1:0] ps1;
        logic [PKG_PREG_W-1:0] ps2;
        logic [PKG_PREG_W-1:0] pd;
        logic [PKG_ROB_W-1:0]  rob_index;
        logic [31:0]           pc;
        logic [31:0]           imm;
    } rs_data;

    typedef struct packed {
        logic   valid;
        logic   rdy1;
        logic   rdy2;
        rs_data data;
    } brs_entry_t;

    // Distance from the ROB head; smaller means older, wrap-around safe.
    function automatic logic [PKG_ROB_W-1:0] rob_age(input logic [PKG_ROB_W-1:0] idx,
                                                     input logic [PKG_ROB_W-1:0] head);
        return idx - head;
    endfunction

endpackage

// File: rtl/branch_age_picker.sv
// Combinational oldest-ready selector: one-hot grant of the ready entry with
// the smallest ROB age relative to rob_head_i.
module branch_age_picker #(
    parameter int DEPTH = 4,
    parameter int ROB_W = 5
) (
    input  logic [DEPTH-1:0]            ready_i,
    input  logic [DEPTH-1:0][ROB_W-1:0] rob_idx_i,
    input  logic [ROB_W-1:0]            rob_head_i,
    output logic [DEPTH-1:0]            grant_o,
    output logic                        found_o
);

    logic [DEPTH-1:0][ROB_W-1:0] age_s;
    logic [ROB_W-1:0]            best_age_s;

    // Per-entry modular age, then a linear min-search over ready entries.
    always_comb begin
        grant_o    = '0;
        found_o    = 1'b0;
        best_age_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age_s[i] = rob_idx_i[i] - rob_head_i;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (ready_i[i] && (!found_o || (age_s[i] < best_age_s))) begin
                grant_o    = '0;
                grant_o[i] = 1'b1;
                found_o    = 1'b1;
                best_age_s = age_s[i];
            end else begin
            end
        end
    end

endmodule

// File: rtl/branch_issue_scheduler.sv
// Branch reservation station: wakeup, oldest-ready issue, mispredict flush.
// Define BRANCH_SCHED_BYPASS_EN for same-cycle issue of a ready op into an empty station.
module branch_issue_scheduler
    import branch_issue_scheduler_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int NUM_WB = 2,
    parameter int PREG_W = PKG_PREG_W,
    parameter int ROB_W  = PKG_ROB_W
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              disp_valid,
    input  rs_data                            disp_data,
    input  logic                              disp_ps1_rdy,
    input  logic                              disp_ps2_rdy,
    output logic                              disp_ready,
    input  logic [NUM_WB-1:0]                 wb_valid,
    input  logic [NUM_WB-1:0][PREG_W-1:0]     wb_preg,
    input  logic [ROB_W-1:0]                  rob_head,
    input  logic                              flush,
    input  logic [ROB_W-1:0]                  flush_tag,
    input  logic                              fu_b_ready,
    output logic                              issued,
    output rs_data                            issue_data,
    output logic [$clog2(DEPTH+1)-1:0]        occupancy
);

    localparam int OCC_W = $clog2(DEPTH+1);

    brs_entry_t                  entries_q [DEPTH];
    brs_entry_t                  entries_d [DEPTH];
    logic [OCC_W-1:0]            occ_q;
    logic [OCC_W-1:0]            occ_d;

    logic [DEPTH-1:0]            ready_s;
    logic [DEPTH-1:0][ROB_W-1:0] rob_idx_s;
    logic [DEPTH-1:0]            grant_s;
    logic                        found_s;
    rs_data                      pick_data_s;
    logic [ROB_W-1:0]            flush_age_s;
    logic                        pick_flushed_s;
    logic                        station_issue_s;
    logic                        disp_ready_s;
    logic                        disp_fire_s;
    logic                        disp_rdy1_s;
    logic                        disp_rdy2_s;
    logic                        bypass_s;
    logic                        disp_write_s;
    logic [DEPTH-1:0]            kill_s;
    logic [DEPTH-1:0]            free_oh_s;
    logic                        free_found_s;
    logic [OCC_W-1:0]            kill_cnt_s;

    // Tag x0 is hardwired and never broadcast as a wakeup.
    function automatic logic tag_hit(input logic [PREG_W-1:0]             tag,
                                     input logic [NUM_WB-1:0]             v,
                                     input logic [NUM_WB-1:0][PREG_W-1:0] p);
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < NUM_WB; w++) begin
            hit = hit | (v[w] && (p[w] == tag));
        end
        return hit && (tag != '0);
    endfunction

    // Issue-eligibility view of the registered entries for the picker.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready_s[i]   = entries_q[i].valid && entries_q[i].rdy1 && entries_q[i].rdy2;
            rob_idx_s[i] = entries_q[i].data.rob_index;
        end
    end

    branch_age_picker #(
        .DEPTH (DEPTH),
        .ROB_W (ROB_W)
    ) u_picker (
        .ready_i    (ready_s),
        .rob_idx_i  (rob_idx_s),
        .rob_head_i (rob_head),
        .grant_o    (grant_s),
        .found_o    (found_s)
    );

    // Issue decision, including flush suppression and the optional bypass path.
    always_comb begin
        pick_data_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant_s[i]) begin
                pick_data_s = entries_q[i].data;
            end else begin
            end
        end
        flush_age_s     = rob_age(flush_tag, rob_head);
        pick_flushed_s  = flush && (rob_age(pick_data_s.rob_index, rob_head) > flush_age_s);
        station_issue_s = found_s && fu_b_ready && !pick_flushed_s;
        disp_ready_s    = (occ_q < OCC_W'(DEPTH));
        disp_fire_s     = disp_valid && disp_ready_s;
        disp_rdy1_s     = disp_ps1_rdy | tag_hit(disp_data.ps1, wb_valid, wb_preg);
        disp_rdy2_s     = disp_ps2_rdy | tag_hit(disp_data.ps2, wb_valid, wb_preg);
`ifdef BRANCH_SCHED_BYPASS_EN
        bypass_s = disp_fire_s && (occ_q == '0) && fu_b_ready && !flush
                   && disp_rdy1_s && disp_rdy2_s;
`else
        bypass_s = 1'b0;
`endif
        disp_write_s = disp_fire_s && !flush && !bypass_s;
    end

    // Entry array next state: wakeup, issue clear, flush clear, dispatch write.
    always_comb begin
        free_oh_s    = '0;
        free_found_s = 1'b0;
        kill_s       = '0;
        kill_cnt_s   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i] = entries_q[i];
            if (!entries_q[i].valid && !free_found_s) begin
                free_oh_s[i] = 1'b1;
                free_found_s = 1'b1;
            end else begin
            end
            if (entries_q[i].valid) begin
                entries_d[i].rdy1 = entries_q[i].rdy1 | tag_hit(entries_q[i].data.ps1, wb_valid, wb_preg);
                entries_d[i].rdy2 = entries_q[i].rdy2 | tag_hit(entries_q[i].data.ps2, wb_valid, wb_preg);
                kill_s[i] = flush && (rob_age(entries_q[i].data.rob_index, rob_head) > flush_age_s);
            end else begin
                kill_s[i] = 1'b0;
            end
            kill_cnt_s = kill_cnt_s + OCC_W'(kill_s[i]);
            if ((station_issue_s && grant_s[i]) || kill_s[i]) begin
                entries_d[i].valid = 1'b0;
            end else if (disp_write_s && free_oh_s[i]) begin
                entries_d[i].valid = 1'b1;
                entries_d[i].rdy1  = disp_rdy1_s;
                entries_d[i].rdy2  = disp_rdy2_s;
                entries_d[i].data  = disp_data;
            end else begin
            end
        end
        occ_d = occ_q + OCC_W'(disp_write_s) - OCC_W'(station_issue_s) - kill_cnt_s;
    end

    // Entry array and occupancy registers; reset empties the station at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            occ_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            occ_q <= occ_d;
        end
    end

    // Issue is combinational from entry state; gated so nothing issues in reset.
    always_comb begin
        issued     = reset && (station_issue_s || bypass_s);
        issue_data = '0;
        if (!reset) begin
            issue_data = '0;
        end else if (bypass_s) begin
            issue_data = disp_data;
        end else if (station_issue_s) begin
            issue_data = pick_data_s;
        end else begin
            issue_data = '0;
        end
        disp_ready = disp_ready_s;
        occupancy  = occ_q;
    end

endmodule

// File: tb/tb_branch_issue_scheduler.sv
// Directed self-checking bench for branch_issue_scheduler (default build, no bypass).
module tb_branch_issue_scheduler;
    import branch_issue_scheduler_pkg::*;

    logic             clk;
    logic             reset;
    logic             disp_valid;
    rs_data           disp_data;
    logic             disp_ps1_rdy;
    logic             disp_ps2_rdy;
    logic             disp_ready;
    logic [1:0]       wb_valid;
    logic [1:0][6:0]  wb_preg;
    logic [4:0]       rob_head;
    logic             flush;
    logic [4:0]       flush_tag;
    logic             fu_b_ready;
    logic             issued;
    rs_data           issue_data;
    logic [2:0]       occupancy;

    int total = 0;
    int bad   = 0;

    branch_issue_scheduler #(.DEPTH(4), .NUM_WB(2), .PREG_W(7), .ROB_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .disp_valid   (disp_valid),
        .disp_data    (disp_data),
        .disp_ps1_rdy (disp_ps1_rdy),
        .disp_ps2_rdy (disp_ps2_rdy),
        .disp_ready   (disp_ready),
        .wb_valid     (wb_valid),
        .wb_preg      (wb_preg),
        .rob_head     (rob_head),
        .flush        (flush),
        .flush_tag    (flush_tag),
        .fu_b_ready   (fu_b_ready),
        .issued       (issued),
        .issue_data   (issue_data),
        .occupancy    (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic put(input logic v, input int rob, input int ps1, input int ps2,
                       input logic r1, input logic r2);
        disp_valid          = v;
        disp_data           = '0;
        disp_data.Opcode    = OPC_BRANCH;
        disp_data.func3     = F3_BNE;
        disp_data.rob_index = 5'(rob);
        disp_data.ps1       = 7'(ps1);
        disp_data.ps2       = 7'(ps2);
        disp_data.pd        = 7'(rob + 40);
        disp_data.pc        = 32'(32'h1000 + rob * 4);
        disp_data.imm       = 32'(rob);
        disp_ps1_rdy        = r1;
        disp_ps2_rdy        = r2;
    endtask

    initial begin
        reset = 1'b0;
        put(1'b0, 0, 0, 0, 1'b0, 1'b0);
        wb_valid   = 2'b00;
        wb_preg    = '0;
        rob_head   = 5'd0;
        flush      = 1'b0;
        flush_tag  = 5'd0;
        fu_b_ready = 1'b1;
        #3;
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_issued", 32'(issued), 32'd0);
        chk("rst_disp_ready", 32'(disp_ready), 32'd1);
        chk("rst_issue_data", 32'(issue_data.rob_index), 32'd0);
        #9 reset = 1'b1;
        tick();

        // basic issue
        put(1'b1, 3, 10, 11, 1'b1, 1'b1);
        #1 chk("basic_no_same_cycle", 32'(issued), 32'd0);
        tick();
        put(1'b0, 0, 0, 0, 1'b0, 1'b0);
        #1 chk("basic_issued", 32'(issued), 32'd1);
        chk("basic_rob", 32'(issue_data.rob_index), 32'd3);
        chk("basic_occ1", 32'(occupancy), 32'd1);
        tick();
        chk("basic_occ0", 32'(occupancy), 32'd0);
        chk("basic_idle", 32'(issued), 32'd0);

        // wakeup ordering
        put(1'b1, 5, 12, 13, 1'b0, 1'b1);
        tick();
        put(1'b1, 6, 14, 15, 1'b1, 1'b1);
        #1 chk("wk_not_ready", 32'(issued), 32'd0);
        tick();
        put(1'b0, 0, 0, 0, 1'b0, 1'b0);
        wb_valid = 2'b01; wb_preg[0] = 7'd12;
        #1 chk("wk_first", 32'(issue_data.rob_index), 32'd6);
        chk("wk_first_v", 32'(issued), 32'd1);
        tick();
        wb_valid = 2'b00;
        #1 chk("wk_second", 32'(issue_data.rob_index), 32'd5);
        chk("wk_second_v", 32'(issued), 32'd1);
        tick();
        chk("wk_occ0", 32'(occupancy), 32'd0);

        // wrap-around age
        rob_head = 5'd30; fu_b_ready = 1'b0;
        put(1'b1, 1, 16, 17, 1'b1, 1'b1);
        tick();
        put(1'b1, 31, 18, 19, 1'b1, 1'b1);
        tick();
        put(1'b0, 0, 0, 0, 1'b0, 1'b0);
        #1 chk("wrap_stall", 32'(issued), 32'd0);
        chk("wrap_occ2", 32'(occupancy), 32'd2);
        fu_b_ready = 1'b1;
        #1 chk("wrap_first", 32'(issue_data.rob_index), 32'd31);
        tick();
        chk("wrap_second", 32'(issue_data.rob_index), 32'd1);
        tick();
        chk("wrap_occ0", 32'(occupancy), 32'd0);

        // flush
        rob_head = 5'd2; fu_b_ready = 1'b0;
        put(1'b1, 4, 20, 22, 1'b0, 1'b1);
        tick();
        put(1'b1, 7, 23, 24, 1'b1, 1'b1);
        tick();
        put(1'b1, 9, 21, 25, 1'b0, 1'b1);
        tick();
        put(1'b0, 0, 0, 0, 1'b0, 1'b0);
        #1 chk("fl_occ3", 32'(occupancy), 32'd3);
        flush = 1'b1; flush_tag = 5'd6; fu_b_ready = 1'b1;
        put(1'b1, 5, 26, 27, 1'b1, 1'b1);
        #1 chk("fl_suppress", 32'(issued), 32'd0);
        chk("fl_disp_ready", 32'(disp_ready), 32'd1);
        tick();
        flush = 1'b0;
        put(1'b0, 0, 0, 0, 1'b0, 1'b0);
        #1 chk("fl_occ1", 32'(occupancy), 32'd1);
        chk("fl_idle", 32'(issued), 32'd0);
        wb_valid = 2'b10; wb_preg[1] = 7'd20;
        tick();
        wb_valid = 2'b00;
        #1 chk("fl_survivor", 32'(issue_data.rob_index), 32'd4);
        chk("fl_survivor_v", 32'(issued), 32'd1);
        tick();
        chk("fl_occ0", 32'(occupancy), 32'd0);

        // same-cycle wakeup merged into a dispatched op
        rob_head = 5'd0;
        put(1'b1, 8, 30, 33, 1'b1, 1'b0);
        wb_valid = 2'b01; wb_preg[0] = 7'd33;
        tick();
        put(1'b0, 0, 0, 0, 1'b0, 1'b0);
        wb_valid = 2'b00;
        #1 chk("dwk_issued", 32'(issued), 32'd1);
        chk("dwk_rob", 32'(issue_data.rob_index), 32'd8);
        tick();

        // full and stall
        fu_b_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            put(1'b1, 10 + k, 50 + k, 60 + k, 1'b1, 1'b1);
            tick();
        end
        put(1'b1, 14, 55, 65, 1'b1, 1'b1);
        #1 chk("full_occ4", 32'(occupancy), 32'd4);
        chk("full_not_ready", 32'(disp_ready), 32'd0);
        tick();
        chk("full_refused", 32'(occupancy), 32'd4);
        fu_b_ready = 1'b1;
        #1 chk("full_oldest", 32'(issue_data.rob_index), 32'd10);
        chk("full_still_full", 32'(disp_ready), 32'd0);
        tick();
        put(1'b0, 0, 0, 0, 1'b0, 1'b0);
        #1 chk("full_ready_again", 32'(disp_ready), 32'd1);
        chk("full_occ3", 32'(occupancy), 32'd3);
        chk("full_next", 32'(issue_data.rob_index), 32'd11);
        tick();
        chk("full_rob12", 32'(issue_data.rob_index), 32'd12);
        tick();
        chk("full_rob13", 32'(issue_data.rob_index), 32'd13);
        tick();
        chk("full_drained", 32'(occupancy), 32'd0);

        // async reset mid-run; rob 1 carries x0 and a tag-0 broadcast must not wake it
        fu_b_ready = 1'b0;
        put(1'b1, 1, 0, 70, 1'b0, 1'b1);
        wb_valid = 2'b01; wb_preg[0] = 7'd0;
        tick();
        wb_valid = 2'b00;
        put(1'b1, 2, 71, 72, 1'b1, 1'b1);
        tick();
        put(1'b1, 3, 73, 74, 1'b1, 1'b1);
        tick();
        put(1'b0, 0, 0, 0, 1'b0, 1'b0);
        #1 chk("ar_occ3", 32'(occupancy), 32'd3);
        fu_b_ready = 1'b1;
        #1 chk("ar_tag0_not_woken", 32'(issue_data.rob_index), 32'd2);
        #1 reset = 1'b0;
        #1 chk("ar_occ0", 32'(occupancy), 32'd0);
        chk("ar_issued0", 32'(issued), 32'd0);
        @(negedge clk) reset = 1'b1;
        tick();
        chk("ar_after_occ", 32'(occupancy), 32'd0);
        chk("ar_after_issued", 32'(issued), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_issue_scheduler.md
# branch_issue_scheduler

Holds dispatched branch and jump ops (BNE, JALR) in a small reservation station. Tracks source-operand readiness via writeback tag broadcasts and issues the oldest ready op, one per cycle, to the branch functional unit. Also removes wrong-path entries when the branch unit signals a mispredict. Sits between dispatch/rename and the branch FU; its issue outputs drive the FU's `data_in`/`issued` inputs and the PRF read addresses.

## Interface
Parameters:
- `DEPTH`, 4: number of station entries, ≥2.
- `NUM_WB`, 2: number of writeback broadcast ports.
- `PREG_W`, 7: physical register tag width.
- `ROB_W`, 5: ROB index width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `disp_valid`  in  1  dispatch offers one branch op this cycle.
- `disp_data`  in  rs_data  op payload, including `ps1`, `ps2`, `pd`, `rob_index`, `pc`, `imm`, `Opcode`, `func3`.
- `disp_ps1_rdy`, `disp_ps2_rdy`  in  1 each  operand already available at dispatch.
- `disp_ready`  out  1  station can accept an op this cycle.
- `wb_valid`  in  NUM_WB  writeback broadcast valid.
- `wb_preg`  in  NUM_WB×PREG_W  broadcast destination tags.
- `rob_head`  in  ROB_W  oldest ROB index (`curr_rob_tag`).
- `flush`  in  1  mispredict from the branch FU.
- `flush_tag`  in  ROB_W  ROB index of the mispredicting branch.
- `fu_b_ready`  in  1  branch FU can accept an op.
- `issued`  out  1  issue valid; connects to the FU `issued` input.
- `issue_data`  out  rs_data  payload of the issued op.
- `occupancy`  out  $clog2(DEPTH+1)  number of valid entries.

## Operation
- Each entry holds: valid, rs_data, rdy1, rdy2.
- **Dispatch:** accepted when `disp_valid && disp_ready`. The op is written to the lowest-index free entry with rdy bits equal to `disp_ps*_rdy`.
- `disp_ready` = (occupancy < DEPTH).
- **Wakeup:** for each valid `wb_valid[i]`, every valid entry whose `ps1` (or `ps2`) equals `wb_preg[i]` sets rdy1 (or rdy2). A tag of 0 is never woken; an op with a source x0 is dispatched with that rdy bit set.
- **Wakeup vs. dispatch, same cycle:** the op being dispatched also compares against that cycle's broadcasts. A match is ORed into its rdy bits.
- **Age:** age(x) = (x − `rob_head`) mod 2^ROB_W, as an unsigned ROB_W-bit subtraction. A smaller age means an older op.
- **Select:** among valid entries with rdy1 && rdy2, pick the one with minimum age.
- **Issue:** when a pick exists and `fu_b_ready` is high, `issued`=1 and `issue_data`=the picked entry. The entry is cleared at the edge. Issue is combinational from entry state.
- **Flush:** when `flush` is high, every entry with age(rob_index) > age(`flush_tag`) is cleared at the edge.
  - An issue candidate that is younger than `flush_tag` is suppressed that cycle.
  - An op dispatched in a flush cycle is dropped. `disp_ready` is still reported normally.
  - The flushing branch itself is not in the station.
- **Occupancy:** `occupancy` is the registered count of valid entries, updated every edge as +dispatched −issued −flushed.

## Timing
- Reset values: all entries invalid, `occupancy`=0, `disp_ready`=1, `issued`=0, `issue_data`='0.
- Reset asserted mid-operation clears every entry immediately. No issue occurs while `reset` is low.
- **Latency:** an op dispatched in cycle N with both operands ready can issue in cycle N+1 at the earliest.
- An op woken by a broadcast in cycle N can issue in cycle N+1.
- At most one dispatch and one issue per cycle.
- **Full:** a same-cycle issue does not raise `disp_ready`. `disp_ready` is based only on registered occupancy.
- **Stall:** `fu_b_ready`=0 holds all entries; the pick is recomputed each cycle.
- **ROB index wrap-around:** handled by the modular age computation. Example: `rob_head`=30, indices 31 and 1 give ages 1 and 3, so index 31 is older.

## Configuration
- `BRANCH_SCHED_BYPASS_EN` defined:
  - When the station is empty, `fu_b_ready`=1, `flush`=0, and the dispatched op has both operands ready (after the wakeup merge), the op issues in the same cycle as dispatch (`issued`=1, `issue_data`=`disp_data`).
  - The op is not written into the station.
- Macro undefined: no bypass; minimum latency is one cycle.

## Structure
- Shared package:
  - existing `rs_data`;
  - new typedef `brs_entry_t` (valid, rdy1, rdy2, rs_data);
  - constants `OPC_JALR`=7'b1100111, `OPC_BRANCH`=7'b1100011, `F3_BNE`=3'b001.
- Sub-module `branch_age_picker`: combinational oldest-ready select. Inputs are the ready vector, the per-entry ROB indices, and `rob_head`. Outputs are a one-hot grant plus a found flag.
- The top level holds the entry array, wakeup logic, flush logic and occupancy counter.

## Test plan
- **Basic issue:** reset; dispatch a BNE with rob 3 and both operands ready, `fu_b_ready`=1 → `issued`=1 the next cycle with `issue_data.rob_index`=3, then `occupancy` goes 1→0.
- **Wakeup ordering:** dispatch rob 5 (ps1=12 not ready), then rob 6 (ready); broadcast `wb_preg`=12 → rob 6 issues first, and rob 5 issues the cycle after the broadcast.
- **Wrap-around age:** `rob_head`=30; entries with rob 1 and rob 31 both ready → rob 31 issues first.
- **Flush:** entries with rob 4, 7 and 9; `flush`=1 with `flush_tag`=6, `rob_head`=2 → only rob 4 remains and `occupancy`=1. A same-cycle candidate rob 7 is not issued.
- **Full and stall:** with DEPTH=4, dispatch 4 ops with `fu_b_ready`=0 → `disp_ready`=0 and a 5th op is refused. Raise `fu_b_ready` → the oldest issues and `disp_ready`=1 the following cycle.
- **Asynchronous reset mid-run:** with 3 valid entries, pull `reset` low between clock edges → `occupancy`=0 and `issued`=0 immediately.
